// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: maximal-length Fibonacci LFSR bit-stream source.
// Emits one serial bit per enabled cycle with a valid strobe, supports
// runtime reseeding with zero-seed substitution, and flags each completed
// period (return to the loaded seed) with max_tick_reg.

module lfsr_stream_gen #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr_reg,
  output logic             lfsr_msb,
  output logic             bit_valid,
  output logic             max_tick_reg,
  output logic [WIDTH-1:0] period_count,
  output logic             seed_err
);

  // Operating mode. The state register records which action was taken on
  // the last edge; the action for the coming edge is chosen from the
  // current inputs so that en/seed_load take effect with one-cycle latency.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [WIDTH-1:0] seed_copy_r;

  logic [WIDTH-1:0] step_state_s;
  logic [WIDTH-1:0] load_value_s;
  logic             seed_zero_s;
  logic             wrap_s;

  logic [WIDTH-1:0] lfsr_next_s;
  logic             msb_next_s;
  logic             valid_next_s;
  logic             tick_next_s;
  logic [WIDTH-1:0] count_next_s;
  logic             err_next_s;
  logic [WIDTH-1:0] seed_copy_next_s;

  // Feedback bit: even parity over the tapped state bits.
  function automatic logic lfsr_feedback(input logic [WIDTH-1:0] value);
    return ^(value & TAPS);
  endfunction

  // One Fibonacci step: shift towards the MSB, feedback enters at bit 0.
  // An all-zero state can only arise from an upset; it is steered back to
  // the default seed instead of locking up.
  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] nxt;
    nxt = {value[WIDTH-2:0], lfsr_feedback(value)};
    if (nxt == {WIDTH{1'b0}}) begin
      nxt = DEFAULT_SEED;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Datapath helpers shared by the action decode below.
  always_comb begin
    seed_zero_s  = (seed == {WIDTH{1'b0}});
    load_value_s = seed_zero_s ? DEFAULT_SEED : seed;
    step_state_s = lfsr_advance(lfsr_reg);
    wrap_s       = (step_state_s == seed_copy_r);
  end

  // Next-mode decode, priority seed_load over en (reset handled in the register).
  always_comb begin
    state_s = ST_HOLD;
    case (state_r)
      ST_HOLD, ST_RUN, ST_LOAD: begin
        if (seed_load) begin
          state_s = ST_LOAD;
        end else if (en) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_HOLD;
      end
    endcase
  end

  // Per-mode next values for the registered outputs and the seed copy.
  always_comb begin
    lfsr_next_s      = lfsr_reg;
    msb_next_s       = lfsr_msb;
    valid_next_s     = 1'b0;
    tick_next_s      = 1'b0;
    count_next_s     = period_count;
    err_next_s       = seed_err;
    seed_copy_next_s = seed_copy_r;
    case (state_s)
      ST_LOAD: begin
        lfsr_next_s      = load_value_s;
        seed_copy_next_s = load_value_s;
        count_next_s     = {WIDTH{1'b0}};
        err_next_s       = seed_zero_s;
      end
      ST_RUN: begin
        lfsr_next_s  = step_state_s;
        msb_next_s   = lfsr_reg[WIDTH-1];
        valid_next_s = 1'b1;
        if (wrap_s) begin
          tick_next_s  = 1'b1;
          count_next_s = {WIDTH{1'b0}};
        end else begin
          tick_next_s  = 1'b0;
          count_next_s = period_count + WIDTH'(1);
        end
      end
      ST_HOLD: begin
        lfsr_next_s = lfsr_reg;
      end
      default: begin
        lfsr_next_s = lfsr_reg;
      end
    endcase
  end

  // State and output registers; reset dominates any pending load or step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_HOLD;
      lfsr_reg     <= DEFAULT_SEED;
      lfsr_msb     <= 1'b0;
      bit_valid    <= 1'b0;
      max_tick_reg <= 1'b0;
      period_count <= {WIDTH{1'b0}};
      seed_err     <= 1'b0;
      seed_copy_r  <= DEFAULT_SEED;
    end else begin
      state_r      <= state_s;
      lfsr_reg     <= lfsr_next_s;
      lfsr_msb     <= msb_next_s;
      bit_valid    <= valid_next_s;
      max_tick_reg <= tick_next_s;
      period_count <= count_next_s;
      seed_err     <= err_next_s;
      seed_copy_r  <= seed_copy_next_s;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Directed testbench for lfsr_stream_gen with an independent golden LFSR.

module tb_lfsr_stream_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        seed_load;
  logic [15:0] seed;
  logic [15:0] lfsr_reg;
  logic        lfsr_msb;
  logic        bit_valid;
  logic        max_tick_reg;
  logic [15:0] period_count;
  logic        seed_err;

  int n_cmp = 0;
  int n_err = 0;

  lfsr_stream_gen #(
    .WIDTH(16),
    .TAPS(16'hB400),
    .DEFAULT_SEED(16'h0001)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .seed_load(seed_load),
    .seed(seed),
    .lfsr_reg(lfsr_reg),
    .lfsr_msb(lfsr_msb),
    .bit_valid(bit_valid),
    .max_tick_reg(max_tick_reg),
    .period_count(period_count),
    .seed_err(seed_err)
  );

  always #5 clk = ~clk;

  // Golden step for x^16+x^14+x^13+x^11+1, written out bit by bit.
  function automatic logic [15:0] gold_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; seed_load = 1'b0; seed = 16'h0000;
    tick(); tick();
    n_cmp++; if (lfsr_reg !== 16'h0001) begin n_err++; $display("FAIL reset_lfsr: got %h want 0001", lfsr_reg); end
    n_cmp++; if (lfsr_msb !== 1'b0) begin n_err++; $display("FAIL reset_msb: got %b want 0", lfsr_msb); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bit_valid); end
    n_cmp++; if (max_tick_reg !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", max_tick_reg); end
    n_cmp++; if (period_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", period_count); end
    n_cmp++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", seed_err); end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL step_valid[%0d]: got %b want 1", i, bit_valid); end
    end
    n_cmp++; if (lfsr_reg !== 16'h0400) begin n_err++; $display("FAIL step10_lfsr: got %h want 0400", lfsr_reg); end
    n_cmp++; if (period_count !== 16'd10) begin n_err++; $display("FAIL step10_count: got %0d want 10", period_count); end
    tick();
    n_cmp++; if (lfsr_reg !== 16'h0801) begin n_err++; $display("FAIL step11_lfsr: got %h want 0801", lfsr_reg); end
    n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL step11_valid: got %b want 1", bit_valid); end
    n_cmp++; if (lfsr_msb !== 1'b0) begin n_err++; $display("FAIL step11_msb: got %b want 0", lfsr_msb); end
    n_cmp++; if (period_count !== 16'd11) begin n_err++; $display("FAIL step11_count: got %0d want 11", period_count); end
  endtask

  task automatic test_full_period();
    logic [15:0] model;
    logic [15:0] prev;
    int          ticks_seen;
    reset = 1'b1; en = 1'b1; seed_load = 1'b0;
    tick();
    reset = 1'b0;
    model = 16'h0001;
    ticks_seen = 0;
    for (int i = 1; i <= 65535; i++) begin
      prev  = model;
      model = gold_next(model);
      tick();
      if (max_tick_reg === 1'b1) ticks_seen++;
      n_cmp++; if (lfsr_reg !== model) begin n_err++; $display("FAIL period_lfsr[%0d]: got %h want %h", i, lfsr_reg, model); end
      n_cmp++; if (lfsr_msb !== prev[15]) begin n_err++; $display("FAIL period_msb[%0d]: got %b want %b", i, lfsr_msb, prev[15]); end
      n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL period_valid[%0d]: got %b want 1", i, bit_valid); end
      n_cmp++; if (max_tick_reg !== (i == 65535)) begin n_err++; $display("FAIL period_tick[%0d]: got %b want %b", i, max_tick_reg, (i == 65535)); end
      n_cmp++; if (period_count !== ((i == 65535) ? 16'd0 : 16'(i))) begin n_err++; $display("FAIL period_count[%0d]: got %0d want %0d", i, period_count, (i == 65535) ? 0 : i); end
      n_cmp++; if (lfsr_reg === 16'h0000) begin n_err++; $display("FAIL period_zero[%0d]: got %h want nonzero", i, lfsr_reg); end
      n_cmp++; if ((i != 65535) && (lfsr_reg === 16'h0001)) begin n_err++; $display("FAIL period_early_seed[%0d]: got %h want not 0001", i, lfsr_reg); end
    end
    n_cmp++; if (lfsr_reg !== 16'h0001) begin n_err++; $display("FAIL period_end_lfsr: got %h want 0001", lfsr_reg); end
    n_cmp++; if (ticks_seen !== 1) begin n_err++; $display("FAIL period_tick_count: got %0d want 1", ticks_seen); end
  endtask

  task automatic test_seed_load();
    logic [15:0] model;
    seed_load = 1'b1; seed = 16'hACE1; en = 1'b1;
    tick();
    n_cmp++; if (lfsr_reg !== 16'hACE1) begin n_err++; $display("FAIL load_lfsr: got %h want ace1", lfsr_reg); end
    n_cmp++; if (period_count !== 16'd0) begin n_err++; $display("FAIL load_count: got %0d want 0", period_count); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL load_valid: got %b want 0", bit_valid); end
    n_cmp++; if (max_tick_reg !== 1'b0) begin n_err++; $display("FAIL load_tick: got %b want 0", max_tick_reg); end
    n_cmp++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL load_err: got %b want 0", seed_err); end
    tick();
    n_cmp++; if (lfsr_reg !== 16'hACE1) begin n_err++; $display("FAIL load2_lfsr: got %h want ace1", lfsr_reg); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL load2_valid: got %b want 0", bit_valid); end
    seed_load = 1'b0;
    model = 16'hACE1;
    for (int i = 1; i <= 1000; i++) begin
      model = gold_next(model);
      tick();
      n_cmp++; if (lfsr_reg !== model) begin n_err++; $display("FAIL ace1_lfsr[%0d]: got %h want %h", i, lfsr_reg, model); end
      n_cmp++; if (period_count !== 16'(i)) begin n_err++; $display("FAIL ace1_count[%0d]: got %0d want %0d", i, period_count, i); end
      n_cmp++; if (max_tick_reg !== 1'b0) begin n_err++; $display("FAIL ace1_tick[%0d]: got %b want 0", i, max_tick_reg); end
    end
  endtask

  task automatic test_zero_seed();
    logic [15:0] model;
    seed_load = 1'b1; seed = 16'h0000; en = 1'b0;
    tick();
    n_cmp++; if (lfsr_reg !== 16'h0001) begin n_err++; $display("FAIL zero_lfsr: got %h want 0001", lfsr_reg); end
    n_cmp++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL zero_err: got %b want 1", seed_err); end
    n_cmp++; if (period_count !== 16'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", period_count); end
    seed_load = 1'b0; en = 1'b1;
    model = 16'h0001;
    for (int i = 1; i <= 5; i++) begin
      model = gold_next(model);
      tick();
      n_cmp++; if (lfsr_reg !== model) begin n_err++; $display("FAIL zero_run_lfsr[%0d]: got %h want %h", i, lfsr_reg, model); end
      n_cmp++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL zero_sticky[%0d]: got %b want 1", i, seed_err); end
    end
    en = 1'b0; seed_load = 1'b1; seed = 16'h1234;
    tick();
    seed_load = 1'b0;
    n_cmp++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL clear_err: got %b want 0", seed_err); end
    n_cmp++; if (lfsr_reg !== 16'h1234) begin n_err++; $display("FAIL clear_lfsr: got %h want 1234", lfsr_reg); end
  endtask

  task automatic test_en_gating();
    logic [15:0] model;
    logic        last_msb;
    model = 16'h1234;
    last_msb = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      last_msb = model[15];
      model = gold_next(model);
      tick();
      n_cmp++; if (lfsr_reg !== model) begin n_err++; $display("FAIL gate_pre_lfsr[%0d]: got %h want %h", i, lfsr_reg, model); end
      n_cmp++; if (period_count !== 16'(i)) begin n_err++; $display("FAIL gate_pre_count[%0d]: got %0d want %0d", i, period_count, i); end
    end
    en = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++; if (lfsr_reg !== model) begin n_err++; $display("FAIL gap_lfsr[%0d]: got %h want %h", i, lfsr_reg, model); end
      n_cmp++; if (period_count !== 16'd100) begin n_err++; $display("FAIL gap_count[%0d]: got %0d want 100", i, period_count); end
      n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL gap_valid[%0d]: got %b want 0", i, bit_valid); end
      n_cmp++; if (max_tick_reg !== 1'b0) begin n_err++; $display("FAIL gap_tick[%0d]: got %b want 0", i, max_tick_reg); end
      n_cmp++; if (lfsr_msb !== last_msb) begin n_err++; $display("FAIL gap_msb[%0d]: got %b want %b", i, lfsr_msb, last_msb); end
    end
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      model = gold_next(model);
      tick();
      n_cmp++; if (lfsr_reg !== model) begin n_err++; $display("FAIL gate_post_lfsr[%0d]: got %h want %h", i, lfsr_reg, model); end
      n_cmp++; if (period_count !== 16'(100 + i)) begin n_err++; $display("FAIL gate_post_count[%0d]: got %0d want %0d", i, period_count, 100 + i); end
      n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL gate_post_valid[%0d]: got %b want 1", i, bit_valid); end
    end
  endtask

  task automatic test_reset_mid_run();
    en = 1'b1; seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    for (int i = 1; i <= 500; i++) tick();
    n_cmp++; if (period_count !== 16'd500) begin n_err++; $display("FAIL mid_count: got %0d want 500", period_count); end
    n_cmp++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL mid_err: got %b want 1", seed_err); end
    reset = 1'b1; seed_load = 1'b1; seed = 16'hBEEF;
    tick();
    n_cmp++; if (lfsr_reg !== 16'h0001) begin n_err++; $display("FAIL rst_lfsr: got %h want 0001", lfsr_reg); end
    n_cmp++; if (period_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", period_count); end
    n_cmp++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", seed_err); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bit_valid); end
    n_cmp++; if (max_tick_reg !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", max_tick_reg); end
    n_cmp++; if (lfsr_msb !== 1'b0) begin n_err++; $display("FAIL rst_msb: got %b want 0", lfsr_msb); end
    reset = 1'b0; seed_load = 1'b0;
    tick();
    n_cmp++; if (lfsr_reg !== 16'h0002) begin n_err++; $display("FAIL rst_step_lfsr: got %h want 0002", lfsr_reg); end
    n_cmp++; if (period_count !== 16'd1) begin n_err++; $display("FAIL rst_step_count: got %0d want 1", period_count); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed = 16'h0000;
    test_reset();
    test_full_period();
    test_seed_load();
    test_zero_seed();
    test_en_gating();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
